// File: rtl/uart_rx_hold.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_hold
// Brief    : 8N1 UART receiver with a one-byte hold register, frame-error
//            pulse and sticky overrun flag.
// Revision : 1.0
// ============================================================================
module uart_rx_hold #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Next,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Overrun,
  output logic       o_Rx_FrameErr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF_C = HALF[CW-1:0];
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    shift, shift_d;
  logic          sync1, rx_s;
  logic          nxt_q;
  logic          stop_good, stop_bad;
  logic          consume;

  assign consume = i_Rx_Next & ~nxt_q & o_Rx_DV;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      sync1 <= i_Rx_Serial;
      rx_s  <= sync1;
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    idx_d     = idx;
    shift_d   = shift;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check the line mid start bit so short low glitches are ignored
        if (cnt == HALF_C) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == LAST_C) begin
          cnt_d        = '0;
          shift_d[idx] = rx_s;
          if (idx == 3'd7) state_d = STOP;
          else             idx_d   = idx + 3'd1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == LAST_C) begin
          cnt_d     = '0;
          stop_good = rx_s;
          stop_bad  = ~rx_s;
          state_d   = CLEANUP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A load in the same cycle as a consume takes priority over the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nxt_q         <= 1'b0;
      o_Rx_DV       <= 1'b0;
      o_Rx_Byte     <= 8'h00;
      o_Rx_Overrun  <= 1'b0;
      o_Rx_FrameErr <= 1'b0;
    end else begin
      nxt_q         <= i_Rx_Next;
      o_Rx_FrameErr <= stop_bad;
      if (consume) begin
        o_Rx_DV      <= 1'b0;
        o_Rx_Overrun <= 1'b0;
      end
      if (stop_good) begin
        if (!o_Rx_DV || consume) begin
          o_Rx_Byte <= shift;
          o_Rx_DV   <= 1'b1;
        end else begin
          o_Rx_Overrun <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_hold
// Brief    : Directed table-driven bench for uart_rx_hold at 8 clocks per bit.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_hold;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       nxt;
  logic       dv;
  logic [7:0] rx_byte;
  logic       ovr;
  logic       fe;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int fe_cnt = 0;
  logic dv_last = 1'b0;

  typedef struct {
    logic       glitch;
    logic [7:0] data;
    logic       stop;
    logic       consume;
    logic       exp_dv;
    logic [7:0] exp_byte;
    logic       exp_ovr;
    int         exp_fe;
  } vec_t;

  vec_t tbl[6];

  uart_rx_hold #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_Rx_Serial  (rx),
    .i_Rx_Next    (nxt),
    .o_Rx_DV      (dv),
    .o_Rx_Byte    (rx_byte),
    .o_Rx_Overrun (ovr),
    .o_Rx_FrameErr(fe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (fe) fe_cnt++;
    if (dv && !dv_last) rise_cyc = cyc;
    dv_last = dv;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Drives one 10-bit frame; next is raised at cycle offset next_at (-1 = never)
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int next_at,
                            input int len);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    start_cyc = cyc;
    fe_cnt = 0;
    for (int c = 0; c < len; c++) begin
      rx = fr[c / CPB];
      if (c == next_at) nxt = 1'b1;
      tick();
    end
    rx = 1'b1;
  endtask

  task automatic consume_now();
    nxt = 1'b1;
    tick();
    check("consume_dv", dv, 0);
    check("consume_ovr", ovr, 0);
    nxt = 1'b0;
    tick();
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 0};
    tbl[1] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0};
    tbl[2] = '{1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 0};
    tbl[3] = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1};
    tbl[4] = '{1'b0, 8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 0};
    tbl[5] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 0};

    rst_n = 1'b0;
    rx    = 1'b1;
    nxt   = 1'b0;
    idle(3);
    check("reset_dv", dv, 0);
    check("reset_byte", rx_byte, 8'h00);
    check("reset_ovr", ovr, 0);
    check("reset_fe", fe, 0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].glitch) begin
        fe_cnt = 0;
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(20);
        check("glitch_dv", dv, 0);
        check("glitch_fe", fe_cnt, 0);
      end
      rise_cyc = -1;
      send_frame(tbl[i].data, tbl[i].stop, -1, 10 * CPB);
      idle(4);
      if (i == 0) begin
        check("latency_window", ((rise_cyc - start_cyc) >= 76) && ((rise_cyc - start_cyc) <= 81), 1);
        check("latency_fe", fe_cnt, 0);
      end
      check("vec_dv", dv, tbl[i].exp_dv);
      check("vec_byte", rx_byte, tbl[i].exp_byte);
      check("vec_ovr", ovr, tbl[i].exp_ovr);
      check("vec_fe_cycles", fe_cnt, tbl[i].exp_fe);
      if (tbl[i].consume) consume_now();
    end

    // Held level on next consumes only once
    nxt = 1'b1;
    tick();
    check("level_first_dv", dv, 0);
    send_frame(8'h3C, 1'b1, -1, 10 * CPB);
    idle(4);
    check("level_hold_dv", dv, 1);
    check("level_hold_byte", rx_byte, 8'h3C);
    nxt = 1'b0;
    tick();
    nxt = 1'b1;
    tick();
    check("level_reedge_dv", dv, 0);
    nxt = 1'b0;
    tick();

    // Consume edge lands on the stop-sample cycle of the second byte
    send_frame(8'h66, 1'b1, -1, 10 * CPB);
    idle(4);
    check("coinc_pre_byte", rx_byte, 8'h66);
    send_frame(8'h77, 1'b1, 78, 10 * CPB);
    idle(4);
    check("coinc_dv", dv, 1);
    check("coinc_byte", rx_byte, 8'h77);
    check("coinc_ovr", ovr, 0);
    nxt = 1'b0;
    tick();

    // Reset in the middle of the data bits
    send_frame(8'h99, 1'b1, -1, 30);
    rst_n = 1'b0;
    idle(3);
    check("midrst_dv", dv, 0);
    check("midrst_byte", rx_byte, 8'h00);
    check("midrst_ovr", ovr, 0);
    rst_n = 1'b1;
    idle(10);
    send_frame(8'hC3, 1'b1, -1, 10 * CPB);
    idle(4);
    check("post_rst_dv", dv, 1);
    check("post_rst_byte", rx_byte, 8'hC3);
    check("post_rst_fe", fe_cnt, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
